// File: rtl/tt_pwm_bank.sv
// tt_pwm_bank: bank of CHANNELS PWM generators sharing one period counter.
//
// Ports:
//   clk      - single clock, all state on rising edge
//   rst      - asynchronous active-high reset
//   ena      - enable; while low, state holds, writes are ignored, uo_out=0
//   ui_in    - [7] write strobe (rising edge), [6] readback request,
//              [2:0] channel select
//   uio_in   - duty value, low WIDTH bits used
//   uo_out   - [CHANNELS-1:0] PWM outputs, upper bits 0
//   uio_out  - readback data (PWM_READBACK_EN builds only, else 0)
//   uio_oe   - uio drive enable (PWM_READBACK_EN builds only, else 0)
//
// Optional feature macro: PWM_READBACK_EN enables the registered duty readback.
//
// Duty writes land in a pending register and are copied to the active
// register at the period wrap, so a duty change never cuts a pulse short.
module tt_pwm_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [PW-1:0]       pre;
  logic [WIDTH-1:0]    cnt;
  logic                strobe_q;
  logic [WIDTH-1:0]    pending [CHANNELS];
  logic [WIDTH-1:0]    active  [CHANNELS];
  logic [CHANNELS-1:0] pwm_q;

  logic                tick;
  logic                wrap;
  logic                write_fire;
  logic [CHANNELS-1:0] hit;
  logic [WIDTH-1:0]    wdata;
  logic                unused_inputs;

  assign tick       = (pre == PRE_MAX);
  assign wrap       = ena && tick && (cnt == CNT_MAX);
  assign write_fire = ena && ui_in[7] && !strobe_q;
  assign wdata      = uio_in[WIDTH-1:0];
  assign unused_inputs = ^{ui_in[6:3], uio_in};

  // A select value with no matching channel leaves hit all-zero, so
  // out-of-range writes change nothing.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      hit[i] = write_fire && (ui_in[2:0] == i[2:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre      <= '0;
      cnt      <= '0;
      strobe_q <= 1'b0;
      pwm_q    <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pending[i] <= '0;
        active[i]  <= '0;
      end
    end else begin
      strobe_q <= ui_in[7];
      if (ena) begin
        pre <= tick ? '0 : pre + PW'(1);
        if (tick) begin
          cnt <= cnt + WIDTH'(1);
        end
      end
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pwm_q[i] <= ena && (cnt < active[i]);
        // A write coinciding with the wrap bypasses pending so the new
        // value starts with the period that begins now.
        if (hit[i]) begin
          pending[i] <= wdata;
          if (wrap) begin
            active[i] <= wdata;
          end
        end else if (wrap) begin
          active[i] <= pending[i];
        end
      end
    end
  end

  always_comb begin
    uo_out = '0;
    if (ena) begin
      uo_out[CHANNELS-1:0] = pwm_q;
    end
  end

`ifdef PWM_READBACK_EN
  logic [WIDTH-1:0] rd_sel;

  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (ui_in[2:0] == i[2:0]) begin
        rd_sel = active[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uio_out <= '0;
      uio_oe  <= '0;
    end else if (ena && ui_in[6]) begin
      uio_out <= 8'(rd_sel);
      uio_oe  <= '1;
    end else begin
      uio_out <= '0;
      uio_oe  <= '0;
    end
  end
`else
  assign uio_out = '0;
  assign uio_oe  = '0;
`endif

endmodule

// File: doc/tt_pwm_bank.md
TT_PWM_BANK -- requirements
Module: tt_pwm_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of PWM channels (legal 1..8).
REQ-002 SHALL have parameter WIDTH, default 8, duty and period counter width in bits (legal 2..8).
REQ-003 SHALL have parameter PRESCALE, default 1, clocks per counter step (legal 1..256).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ena  input  1  design-selected enable.
REQ-007 SHALL have port ui_in  input  8  [7]=write strobe, [6]=readback request, [2:0]=channel select.
REQ-008 SHALL have port uio_in  input  8  duty value; low WIDTH bits used.
REQ-009 SHALL have port uo_out  output  8  [CHANNELS-1:0]=PWM outputs; other bits 0.
REQ-010 SHALL have port uio_out  output  8  readback data (see Configuration).
REQ-011 SHALL have port uio_oe  output  8  uio drive enable, 1=output.

Function
REQ-012 SHALL keep a prescaler counting 0..PRESCALE-1; a tick occurs on the cycle it equals PRESCALE-1, then it wraps to 0.
REQ-013 SHALL keep one shared period counter cnt, WIDTH bits, incremented by 1 on each tick, wrapping from 2^WIDTH-1 to 0 (a wrap).
REQ-014 SHALL register ui_in[7] each cycle; a write fires on the cycle the registered copy is 0 and ui_in[7] is 1 (rising edge, one write per edge).
REQ-015 SHALL on a write store uio_in[WIDTH-1:0] into pending[sel] at that clock edge, sel=ui_in[2:0]; sel>=CHANNELS SHALL be ignored with no state change.
REQ-016 SHALL copy every pending[i] into active[i] at the clock edge of a wrap (glitch-free update at period boundary).
REQ-017 SHALL, on a write and a wrap in the same cycle, load the newly written value directly into active[sel] and pending[sel].
REQ-018 SHALL drive uo_out[i] registered, = (cnt < active[i]); duty 0 gives constant 0, duty 2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH steps.
REQ-019 SHALL, while ena=0, hold prescaler, cnt, pending and active, ignore writes, force uo_out to 0, and still update the strobe register.
REQ-020 SHALL NOT produce more than one PWM rising edge per channel per period.

Reset
REQ-021 SHALL on rst=1, immediately and independent of clk, clear prescaler, cnt, strobe register, all pending and active to 0, uo_out to 0, uio_out to 0, uio_oe to 0.
REQ-022 SHALL, on reset asserted mid-period, restart a full period from cnt=0 after release, with all duties 0.

Configuration
REQ-023 SHALL support macro PWM_READBACK_EN.
REQ-024 SHALL, with PWM_READBACK_EN defined, drive uio_oe=8'hFF and uio_out={0..., active[sel]} registered one cycle after ui_in[6]=1 and ena=1; otherwise uio_oe=0 and uio_out=0; sel>=CHANNELS reads 0.
REQ-025 SHALL, without PWM_READBACK_EN, tie uio_oe and uio_out to 0 and ignore ui_in[6].

Verification (CHANNELS=4, WIDTH=8, PRESCALE=1)
REQ-026 SHALL cover: write 8'd64 to ch0, wait one wrap -> uo_out[0] high exactly 64 of every 256 cycles.
REQ-027 SHALL cover: write 8'd0 to ch1 and 8'd255 to ch2 -> uo_out[1] never high; uo_out[2] low exactly 1 cycle per 256.
REQ-028 SHALL cover: mid-period write ch0 8'd200 while active=64 -> current period still 64 high cycles, next period 200.
REQ-029 SHALL cover: strobe held high 10 cycles with sel=5 then sel=3 -> no state change for sel=5, single write to ch3 only on rising edge.
REQ-030 SHALL cover: ena=0 for 50 cycles mid-period -> uo_out=0, cnt frozen; ena=1 -> period resumes from frozen cnt.
REQ-031 SHALL cover: rst pulse at cnt=100 with no clk edge -> all outputs 0 immediately; with PWM_READBACK_EN, readback of ch0 after write 8'd77 and one wrap -> uio_out=8'd77, uio_oe=8'hFF.
